// File: rtl/mac_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_lane_pipe
// Brief    : Two-stage multi-lane signed multiply-accumulate with optional
//            saturation and a valid/ready result port.
// Revision : 1.0
// ============================================================================
module mac_lane_pipe #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   in_a,
  input  logic [LANES*B_W-1:0]   in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_acc,
  output logic                   out_sat,
  output logic                   sat_pulse
);

  localparam int P_W   = A_W + B_W;
  localparam int NP    = 1 << $clog2(LANES);
  localparam int EXT_W = ACC_W - P_W;
  localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                    stall_w;
  logic                    accept_w;
  logic                    s2_fire_w;
  logic signed [P_W-1:0]   prod_w [LANES];
  logic signed [P_W-1:0]   prod_q [LANES];
  logic [ACC_W-1:0]        tree_sum_w;
  logic [ACC_W:0]          sum_w;
  logic                    ovf_w;
  logic [ACC_W-1:0]        step_w;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q,  s1_last_d;
  logic [ACC_W-1:0]        acc_q,      acc_d;
  logic                    sat_q,      sat_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_acc_q,  out_acc_d;
  logic                    out_sat_q,  out_sat_d;
  logic                    sat_pulse_q, sat_pulse_d;

  assign stall_w   = out_valid_q & ~out_ready;
  assign in_ready  = ~stall_w & ~clr;
  assign accept_w  = in_valid & in_ready;
  assign s2_fire_w = s1_valid_q & ~stall_w;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign prod_w[gi] = $signed(in_a[gi*A_W +: A_W]) * $signed(in_b[gi*B_W +: B_W]);
  end

  // Balanced tree over a power-of-two leaf set; unused leaves are zero.
  always_comb begin : p_tree
    logic [ACC_W-1:0] node [2*NP-1];
    for (int i = 0; i < 2*NP-1; i++) node[i] = '0;
    for (int i = 0; i < LANES; i++) begin
      node[NP-1+i] = {{EXT_W{prod_q[i][P_W-1]}}, prod_q[i]};
    end
    for (int k = NP-2; k >= 0; k--) begin
      node[k] = node[2*k+1] + node[2*k+2];
    end
    tree_sum_w = node[0];
  end

  assign sum_w = {acc_q[ACC_W-1], acc_q} + {tree_sum_w[ACC_W-1], tree_sum_w};
  assign ovf_w = sum_w[ACC_W] ^ sum_w[ACC_W-1];

  // The extra top bit carries the true sign, so it picks the clamp direction.
  always_comb begin
    step_w = sum_w[ACC_W-1:0];
    if (ovf_w && (SAT != 0)) begin
      step_w = sum_w[ACC_W] ? C_MIN : C_MAX;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    sat_pulse_d = s2_fire_w & ovf_w;

    if (!stall_w) begin
      s1_valid_d = accept_w;
      if (accept_w) s1_last_d = in_last;
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (s2_fire_w) begin
      if (s1_last_q) begin
        out_valid_d = 1'b1;
        out_acc_d   = step_w;
        out_sat_d   = sat_q | ovf_w;
        acc_d       = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d = step_w;
        sat_d = sat_q | ovf_w;
      end
    end

    // Abort wins over the S2 update but leaves the result register alone.
    if (clr) begin
      s1_valid_d = 1'b0;
      acc_d      = '0;
      sat_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
      sat_pulse_q <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
      sat_pulse_q <= sat_pulse_d;
      if (accept_w) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_w[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;
  assign sat_pulse = sat_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_lane_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_lane_pipe
// Brief    : Scoreboard bench driving a saturating and a wrapping instance.
// Revision : 1.0
// ============================================================================
module tb_mac_lane_pipe;

  localparam int     LANES = 4;
  localparam int     ACC_W = 20;
  localparam longint MAXV  = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint MINV  = -(longint'(1) << (ACC_W-1));
  localparam longint MODV  = longint'(1) << ACC_W;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready_s, in_ready_w, out_valid_s, out_valid_w;
  logic out_sat_s, out_sat_w, pulse_s, pulse_w;
  logic [ACC_W-1:0] out_acc_s, out_acc_w;

  always #5 clk = ~clk;

  mac_lane_pipe #(.A_W(8), .B_W(8), .LANES(LANES), .ACC_W(ACC_W), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_acc(out_acc_s), .out_sat(out_sat_s), .sat_pulse(pulse_s));

  mac_lane_pipe #(.A_W(8), .B_W(8), .LANES(LANES), .ACC_W(ACC_W), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_acc(out_acc_w), .out_sat(out_sat_w), .sat_pulse(pulse_w));

  typedef struct {
    longint acc_s;
    bit     sat_s;
    longint acc_w;
    bit     sat_w;
  } res_t;

  res_t   exp_q[$];
  longint got_s[$], got_w[$];
  bit     got_sat_s[$], got_sat_w[$];
  int     checks = 0, failures = 0;
  longint m_acc_s = 0, m_acc_w = 0;
  bit     m_st_s = 0, m_st_w = 0;
  int     exp_pul_s = 0, exp_pul_w = 0, pul_s = 0, pul_w = 0;
  bit     rnd_rdy = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrapv(input longint v);
    longint m;
    m = v & (MODV - 1);
    if (m > MAXV) m -= MODV;
    return m;
  endfunction

  // Reference: a dot product is the sum of lane products, folded into a
  // bounded signed accumulator one beat at a time.
  task automatic model_beat(input logic [31:0] a, input logic [31:0] b, input bit last);
    longint dot, s, w;
    dot = 0;
    for (int i = 0; i < LANES; i++)
      dot += longint'($signed(a[8*i +: 8])) * longint'($signed(b[8*i +: 8]));
    s = m_acc_s + dot;
    if (s > MAXV || s < MINV) begin
      exp_pul_s++;
      m_st_s = 1;
      s = (s > MAXV) ? MAXV : MINV;
    end
    w = m_acc_w + dot;
    if (w > MAXV || w < MINV) begin
      exp_pul_w++;
      m_st_w = 1;
      w = wrapv(w);
    end
    if (last) begin
      exp_q.push_back('{s, m_st_s, w, m_st_w});
      m_acc_s = 0; m_acc_w = 0; m_st_s = 0; m_st_w = 0;
    end else begin
      m_acc_s = s; m_acc_w = w;
    end
  endtask

  task automatic model_clear();
    m_acc_s = 0; m_acc_w = 0; m_st_s = 0; m_st_w = 0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last);
    bit ok;
    ok = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready_s;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (ok) model_beat(a, b, last);
    else begin
      checks++; failures++;
      $display("FAIL send_timeout: got in_ready=0 expected beat accepted");
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    pul_s = 0; pul_w = 0; exp_pul_s = 0; exp_pul_w = 0;
  endtask

  task automatic monitor();
    res_t e;
    forever begin
      @(negedge clk);
      if (pulse_s) pul_s++;
      if (pulse_w) pul_w++;
      if (out_valid_s && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: got %0d expected none", $signed(out_acc_s));
        end else begin
          e = exp_q.pop_front();
          check("acc_sat", $signed(out_acc_s), e.acc_s);
          check("flag_sat", out_sat_s, e.sat_s);
          check("valid_wrap", out_valid_w, 1);
          check("acc_wrap", $signed(out_acc_w), e.acc_w);
          check("flag_wrap", out_sat_w, e.sat_w);
          got_s.push_back($signed(out_acc_s));
          got_w.push_back($signed(out_acc_w));
          got_sat_s.push_back(out_sat_s);
          got_sat_w.push_back(out_sat_w);
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int n0;
    logic [31:0] av, bv;
    fork
      monitor();
      ready_driver();
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_out_acc", out_acc_s, 0);
    check("rst_out_sat", out_sat_s, 0);
    check("rst_sat_pulse", pulse_s, 0);
    check("rst_in_ready", in_ready_s, 1);
    @(posedge clk);
    #1;

    // Single beat: 1*5+2*6+3*7+4*8 = 70, two-cycle latency.
    send({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
    @(negedge clk);
    check("latency_n1_valid", out_valid_s, 0);
    @(negedge clk);
    check("latency_n2_valid", out_valid_s, 1);
    check("dot70_acc", $signed(out_acc_s), 70);
    drain();
    check("dot70_pulses", pul_s, 0);

    // Three extreme-negative beats then a restart.
    for (int i = 0; i < 3; i++) send(32'h80808080, 32'h80808080, i == 2);
    send(32'h01010101, 32'h01010101, 1'b1);
    drain();
    check("neg3_acc", got_s[got_s.size()-2], 196608);
    check("restart_acc", got_s[got_s.size()-1], 4);

    // Positive overflow on step nine.
    clear_pulses();
    for (int i = 0; i < 9; i++) send(32'h7f7f7f7f, 32'h7f7f7f7f, i == 8);
    drain();
    check("pos_sat_acc", got_s[got_s.size()-1], 524287);
    check("pos_wrap_acc", got_w[got_w.size()-1], -467932);
    check("pos_sat_flag", got_sat_s[got_sat_s.size()-1], 1);
    check("pos_wrap_flag", got_sat_w[got_sat_w.size()-1], 1);
    check("pos_pulses_sat", pul_s, 1);
    check("pos_pulses_wrap", pul_w, 1);

    // Negative overflow.
    clear_pulses();
    for (int i = 0; i < 9; i++) send(32'h80808080, 32'h7f7f7f7f, i == 8);
    drain();
    check("neg_sat_acc", got_s[got_s.size()-1], -524288);
    check("neg_wrap_acc", got_w[got_w.size()-1], 463360);
    check("neg_pulses_sat", pul_s, 1);

    // Backpressure with one in-flight last beat held in the pipe.
    n0 = got_s.size();
    out_ready = 1'b0;
    send(32'h01010101, 32'h02020202, 1'b1);
    send(32'h03030303, 32'h01010101, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready", in_ready_s, 0);
    check("bp_out_valid", out_valid_s, 1);
    check("bp_acc_hold", $signed(out_acc_s), 8);
    repeat (3) @(negedge clk);
    check("bp_acc_stable", $signed(out_acc_s), 8);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    check("bp_count", got_s.size() - n0, 2);
    check("bp_first", got_s[n0], 8);
    check("bp_second", got_s[n0+1], 12);

    // Abort two partial beats; a beat presented during clr is dropped.
    n0 = got_s.size();
    send(32'h01010101, 32'h01010101, 1'b0);
    send(32'h01010101, 32'h01010101, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    in_a = 32'h05050505; in_b = 32'h05050505;
    @(negedge clk);
    check("clr_in_ready", in_ready_s, 0);
    @(posedge clk);
    #1 clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_clear();
    send(32'h00000002, 32'h00000003, 1'b1);
    drain();
    check("clr_count", got_s.size() - n0, 1);
    check("clr_acc", got_s[got_s.size()-1], 6);
    check("clr_flag", got_sat_s[got_sat_s.size()-1], 0);

    // Asynchronous reset with a result pending and a beat in flight.
    n0 = got_s.size();
    out_ready = 1'b0;
    send(32'h01010101, 32'h01010101, 1'b1);
    send(32'h02020202, 32'h02020202, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid_s, 0);
    check("arst_out_acc", out_acc_s, 0);
    exp_q.delete();
    model_clear();
    clear_pulses();
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    send(32'h00000005, 32'h00000005, 1'b1);
    drain();
    check("arst_count", got_s.size() - n0, 1);
    check("arst_acc", got_s[got_s.size()-1], 25);

    // Randomised traffic with random backpressure.
    clear_pulses();
    rnd_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < LANES; i++) begin
        case (mode)
          0:       begin av[8*i +: 8] = 8'($urandom); bv[8*i +: 8] = 8'($urandom); end
          1:       begin av[8*i +: 8] = 8'h7f; bv[8*i +: 8] = 8'h7f; end
          2:       begin av[8*i +: 8] = 8'h80; bv[8*i +: 8] = 8'h7f; end
          default: begin av[8*i +: 8] = 8'($urandom_range(0, 15)); bv[8*i +: 8] = 8'($urandom); end
        endcase
      end
      send(av, bv, (n == 399) || ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
    check("rnd_pulses_sat", pul_s, exp_pul_s);
    check("rnd_pulses_wrap", pul_w, exp_pul_w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
